// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// freq_meter_pkg : shared constants, FSM encoding and clog2 helper
// Revision 1.0
// ============================================================================
package freq_meter_pkg;

    localparam int CLK_FREQ_HZ = 65_000_000;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    function automatic int clog2(input longint value);
        longint v;
        int     r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
// ============================================================================
// freq_meter_if : measured signal in, period/high-time results out
// Revision 1.0
// ============================================================================
interface freq_meter_if #(
    parameter int CNT_WIDTH = 26
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 timeout;

    modport master (
        output sig_in,
        input  period, high_time, valid, timeout
    );

    modport slave (
        input  sig_in,
        output period, high_time, valid, timeout
    );
endinterface
`default_nettype wire

// File: rtl/freq_meter_sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : 2-FF synchronizer with history flop and rising-edge detect
// Revision 1.0
// ============================================================================
module sync_edge (
    input  wire logic clk65MHz,
    input  wire logic rst,
    input  wire logic async_in,
    output logic      sync_out,
    output logic      rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_out = s2_q;
    assign rise     = s2_q & ~s3_q;
endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// freq_meter : measures period and high time of a slow square wave in clk
//              cycles, with a per-period valid strobe and sticky timeout
// Revision 1.0
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_WIDTH = 26,
    parameter int TIMEOUT   = CLK_FREQ_HZ
) (
    input  wire logic    clk65MHz,
    input  wire logic    rst,
    freq_meter_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;

    // The counter bound relies on TIMEOUT fitting in the counter width.
    if (clog2(longint'(TIMEOUT) + 1) > CNT_WIDTH) begin : g_timeout_too_wide
        $error("freq_meter: TIMEOUT does not fit in CNT_WIDTH bits");
    end

    logic sig_sync;
    logic sig_rise;

    sync_edge u_sync_edge (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .async_in (bus.sig_in),
        .sync_out (sig_sync),
        .rise     (sig_rise)
    );

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (sig_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                    hcnt_d  = CNT_ZERO;
                end
            end
            ST_MEASURE: begin
                // A rise on the timeout cycle still closes a valid period.
                if (sig_rise) begin
                    period_d    = cnt_q;
                    high_time_d = hcnt_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = CNT_ONE;
                    hcnt_d      = CNT_ONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d     = ST_IDLE;
                    timeout_d   = 1'b1;
                    period_d    = CNT_ZERO;
                    high_time_d = CNT_ZERO;
                    cnt_d       = CNT_ZERO;
                    hcnt_d      = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (sig_sync) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// tb_freq_meter : directed self-checking bench for freq_meter
// Revision 1.0
// ============================================================================
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int W = 26;

    logic clk65MHz = 1'b0;
    logic rst      = 1'b0;
    logic sig      = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    always #5 clk65MHz = ~clk65MHz;

    freq_meter_if #(.CNT_WIDTH(W)) bus_a ();
    freq_meter_if #(.CNT_WIDTH(W)) bus_b ();
    assign bus_a.sig_in = sig;
    assign bus_b.sig_in = sig;

    freq_meter #(.CNT_WIDTH(W), .TIMEOUT(100)) u_dut (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .bus      (bus_a.slave)
    );

    freq_meter #(.CNT_WIDTH(W), .TIMEOUT(8)) u_dut8 (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .bus      (bus_b.slave)
    );

    function automatic logic wave(input int i, input int per, input int hi);
        return (i % per) < hi;
    endfunction

    task automatic tick();
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic do_reset();
        sig = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        sig = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        total++; if (bus_a.period !== 26'd0) begin bad++; $display("FAIL reset_period: got %0d expected 0", bus_a.period); end
        total++; if (bus_a.high_time !== 26'd0) begin bad++; $display("FAIL reset_high: got %0d expected 0", bus_a.high_time); end
        total++; if (bus_a.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", bus_a.valid); end
        total++; if (bus_a.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %0b expected 0", bus_a.timeout); end
        total++; if (u_dut.state_q !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", u_dut.state_q, ST_IDLE); end
        total++; if (bus_b.period !== 26'd0 || bus_b.timeout !== 1'b0) begin bad++; $display("FAIL reset_dut8: got period=%0d timeout=%0b expected 0/0", bus_b.period, bus_b.timeout); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_square();
        int nval = 0;
        int last = -1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            sig = wave(i, 8, 4);
            tick();
            if (bus_a.valid) begin
                nval++;
                total++; if (bus_a.period !== 26'd8) begin bad++; $display("FAIL sq_period: got %0d expected 8", bus_a.period); end
                total++; if (bus_a.high_time !== 26'd4) begin bad++; $display("FAIL sq_high: got %0d expected 4", bus_a.high_time); end
                if (nval == 1) begin
                    total++; if (i !== 10) begin bad++; $display("FAIL sq_first_valid_cycle: got %0d expected 10", i); end
                end else begin
                    total++; if (i - last !== 8) begin bad++; $display("FAIL sq_valid_spacing: got %0d expected 8", i - last); end
                end
                last = i;
            end
        end
        total++; if (nval !== 4) begin bad++; $display("FAIL sq_valid_count: got %0d expected 4", nval); end
        total++; if (bus_a.timeout !== 1'b0) begin bad++; $display("FAIL sq_timeout: got %0b expected 0", bus_a.timeout); end
    endtask

    task automatic test_duty();
        int nval = 0;
        int exp_hi;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            sig = (i < 40) ? wave(i, 10, 3) : wave(i, 10, 6);
            tick();
            if (bus_a.valid) begin
                nval++;
                exp_hi = (i < 47) ? 3 : 6;
                total++; if (bus_a.period !== 26'd10) begin bad++; $display("FAIL duty_period: got %0d expected 10", bus_a.period); end
                total++; if (bus_a.high_time !== 26'(exp_hi)) begin bad++; $display("FAIL duty_high at %0d: got %0d expected %0d", i, bus_a.high_time, exp_hi); end
            end
        end
        total++; if (nval !== 7) begin bad++; $display("FAIL duty_valid_count: got %0d expected 7", nval); end
    endtask

    task automatic test_timeout();
        int nval = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sig = wave(i, 8, 4);
            tick();
        end
        sig = 1'b0;
        for (int i = 16; i < 116; i++) begin
            tick();
            if (bus_a.valid) begin
                total++; bad++; $display("FAIL to_spurious_valid at %0d: got 1 expected 0", i);
            end
            if (i == 109) begin
                total++; if (bus_a.timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %0b expected 0", bus_a.timeout); end
                total++; if (bus_a.period !== 26'd8) begin bad++; $display("FAIL to_period_before: got %0d expected 8", bus_a.period); end
            end
            if (i == 110) begin
                total++; if (bus_a.timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %0b expected 1", bus_a.timeout); end
                total++; if (bus_a.period !== 26'd0) begin bad++; $display("FAIL to_period_clear: got %0d expected 0", bus_a.period); end
                total++; if (bus_a.high_time !== 26'd0) begin bad++; $display("FAIL to_high_clear: got %0d expected 0", bus_a.high_time); end
                total++; if (u_dut.state_q !== ST_IDLE) begin bad++; $display("FAIL to_state: got %0d expected %0d", u_dut.state_q, ST_IDLE); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            sig = wave(i, 8, 4);
            tick();
            if (i == 5) begin
                total++; if (bus_a.timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %0b expected 1", bus_a.timeout); end
            end
            if (bus_a.valid) begin
                nval++;
                total++; if (bus_a.period !== 26'd8 || bus_a.high_time !== 26'd4) begin bad++; $display("FAIL to_recover_meas: got %0d/%0d expected 8/4", bus_a.period, bus_a.high_time); end
            end
        end
        total++; if (nval !== 2) begin bad++; $display("FAIL to_recover_count: got %0d expected 2", nval); end
        total++; if (bus_a.timeout !== 1'b0) begin bad++; $display("FAIL to_recover_clear: got %0b expected 0", bus_a.timeout); end
    endtask

    task automatic test_async_reset();
        int nval = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            sig = wave(i, 8, 4);
            tick();
        end
        total++; if (bus_a.period !== 26'd8) begin bad++; $display("FAIL ar_pre_period: got %0d expected 8", bus_a.period); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus_a.period !== 26'd0 || bus_a.high_time !== 26'd0) begin bad++; $display("FAIL ar_immediate: got %0d/%0d expected 0/0", bus_a.period, bus_a.high_time); end
        total++; if (bus_a.valid !== 1'b0 || bus_a.timeout !== 1'b0) begin bad++; $display("FAIL ar_flags: got %0b/%0b expected 0/0", bus_a.valid, bus_a.timeout); end
        sig = 1'b0;
        repeat (2) @(posedge clk65MHz);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig = wave(i, 8, 4);
            tick();
            if (bus_a.valid) begin
                nval++;
                if (nval == 1) begin
                    total++; if (i !== 10) begin bad++; $display("FAIL ar_first_valid_cycle: got %0d expected 10", i); end
                end
                total++; if (bus_a.period !== 26'd8) begin bad++; $display("FAIL ar_period: got %0d expected 8", bus_a.period); end
            end
        end
        total++; if (nval !== 2) begin bad++; $display("FAIL ar_valid_count: got %0d expected 2", nval); end
    endtask

    task automatic test_coincident();
        int nval = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            sig = wave(i, 8, 4);
            tick();
            total++; if (bus_b.timeout !== 1'b0) begin bad++; $display("FAIL co_timeout at %0d: got %0b expected 0", i, bus_b.timeout); end
            if (bus_b.valid) begin
                nval++;
                total++; if (bus_b.period !== 26'd8) begin bad++; $display("FAIL co_period: got %0d expected 8", bus_b.period); end
            end
        end
        total++; if (nval !== 4) begin bad++; $display("FAIL co_valid_count: got %0d expected 4", nval); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_timeout();
        test_async_reset();
        test_coincident();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
